uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver for the ALU-UART datapath, 16x oversampled. It consumes the single-cycle tick pulses from the baud-rate tick generator (16 ticks per bit period). It deserialises 8N1 frames from the board's RX pin, LSB first. Each received byte is presented with a one-cycle done strobe to the interface/ALU control logic.

Parameters:
NB_DATA, 8, data bits per frame
NB_STOP_TICKS, 16, ticks spent sampling the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
OVERSAMPLE, 16, ticks per bit period; must match the tick generator

Ports:
i_clock  input  1  system clock
i_reset  input  1  asynchronous, active-low reset
i_tick  input  1  oversampling tick, one i_clock cycle wide, from the baud-rate tick generator
i_rx  input  1  serial line, idle high, asynchronous to i_clock
o_data  output  NB_DATA  last received byte, held until the next frame completes
o_rx_done  output  1  one-cycle strobe; o_data and o_frame_err are valid in this cycle
o_frame_err  output  1  stop bit sampled low in the frame just completed
o_busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: asserted when i_reset=0, asynchronously. On reset: state=IDLE, sync flops=1, tick count s=0, bit count n=0, shift reg=0, o_data=0, o_rx_done=0, o_frame_err=0, o_busy=0.
- i_rx passes through a 2-flop synchroniser, giving rx_s. All decisions use rx_s, which adds 2 cycles of input latency.
- s is a counter of width $clog2(max(OVERSAMPLE,NB_STOP_TICKS)). n is a counter of width $clog2(NB_DATA). Both advance only on cycles with i_tick=1.
- IDLE: when rx_s=0 (ticks not required) → START, s=0.
- START, on each tick:
  - If s==OVERSAMPLE/2-1 (mid start bit) and rx_s=0 → DATA, s=0, n=0.
  - If s==OVERSAMPLE/2-1 and rx_s=1 → IDLE. This is a glitch: no strobe, no error.
  - Otherwise s++.
- DATA, on each tick:
  - If s==OVERSAMPLE-1: shift rx_s into the MSB of the shift reg (right shift, so LSB-first order is preserved), s=0. Then if n==NB_DATA-1 → STOP, else n++.
  - Otherwise s++.
- STOP, on each tick:
  - If s==NB_STOP_TICKS-1: o_data<=shift reg, o_frame_err<=~rx_s, o_rx_done<=1 for exactly one cycle, → IDLE.
  - Otherwise s++.
- A frame error still delivers the data and the strobe. o_frame_err holds its value until the next done strobe.
- Frame latency: the done strobe occurs 1 cycle after the tick that samples the stop bit.
- Back-to-back frames: IDLE may re-enter START on the cycle after the strobe. No dead time is required beyond that.
- i_tick while in IDLE is ignored.
- A line held low after a frame error re-triggers START. This is the accepted break behaviour: it yields a frame_err frame with data 0 every frame time.
- Reset mid-frame aborts with no strobe. The partial frame is discarded.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP. It samples one bit at s==OVERSAMPLE-1.
  - Even parity: the error is XOR(data bits, parity bit)!=0.
  - Adds output port o_parity_err (1 bit, reset 0), updated with the done strobe with the same hold rule as o_frame_err.
- Undefined: no PARITY state and no o_parity_err port; the frame is 8N1.

Decomposition:
- Package uart_pkg:
  - State encoding constants ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (3-bit).
  - UART_OVERSAMPLE=16.
  - Default NB_DATA and NB_STOP_TICKS.
  - Shared with the future uart_tx.
- One sub-module, sync_2ff: a generic 2-flop synchroniser with reset value parameter RST_VAL=1. It is reused for other asynchronous inputs.

Test Plan:
- Setup: CLK 50 MHz, tick every 163 clocks (19200 baud). Ticks run continuously.
- Frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,stop 1) → one o_rx_done pulse, o_data=0xA5, o_frame_err=0, o_busy high for the frame then low.
- Low glitch of 4 tick periods on an idle line → return to IDLE at mid-start; no o_rx_done; o_data keeps its previous value.
- Frame 0x3C with stop bit driven 0 → o_rx_done pulses, o_data=0x3C, o_frame_err=1. The next clean frame 0x01 → o_frame_err=0.
- Back-to-back 0x00 then 0xFF with no idle gap → two strobes, exactly 10 bit periods (160 ticks) apart, data 0x00 then 0xFF.
- i_reset=0 pulse for 3 clocks during data bit 4 of 0x55, then frame 0x81 → reset values observed immediately (asynchronously); no strobe for the aborted frame; next strobe has o_data=0x81.
- With UART_RX_PARITY_EN, 0x07 with parity bit 1 → o_parity_err=0. The same byte with parity bit 0 → o_parity_err=1, data still 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
// Used by uart_rx and intended for reuse by the companion transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE    = 16;
  localparam int UART_NB_DATA       = 8;
  localparam int UART_NB_STOP_TICKS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
// RST_VAL selects the value both stages take during reset (1 for idle-high lines).
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give metastability time before the value is used.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      meta <= {WIDTH{RST_VAL}};
      o_q  <= {WIDTH{RST_VAL}};
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, 8N1 by default, LSB first.
// Optional even-parity bit and o_parity_err port when UART_RX_PARITY_EN is defined.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | line idle, waiting for rx_s low
//   ST_START  | timing to mid start bit; high there means glitch, go idle
//   ST_DATA   | sampling NB_DATA bits at the centre of each bit period
//   ST_PARITY | (UART_RX_PARITY_EN only) sampling the parity bit
//   ST_STOP   | waiting NB_STOP_TICKS, then sampling stop bit and strobing
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA       = UART_NB_DATA,
  parameter int NB_STOP_TICKS = UART_NB_STOP_TICKS,
  parameter int OVERSAMPLE    = UART_OVERSAMPLE
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic               o_parity_err,
`endif
  output logic               o_busy
);

  localparam int S_W = $clog2(max_int(OVERSAMPLE, NB_STOP_TICKS));
  localparam int N_W = $clog2(NB_DATA);

  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(NB_STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_t ST_AFTER_DATA = ST_STOP;
`endif

  uart_state_t        state;
  logic [S_W-1:0]     s;
  logic [N_W-1:0]     n;
  logic [NB_DATA-1:0] shift_reg;
  logic               rx_s;
`ifdef UART_RX_PARITY_EN
  logic               parity_bit;
`endif

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // Receive FSM: tick-driven bit timing, shifting, and registered result outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      s            <= '0;
      n            <= '0;
      shift_reg    <= '0;
      o_data       <= '0;
      o_rx_done    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Start detection does not wait for a tick so back-to-back frames
          // lose no time after the strobe.
          if (!rx_s) begin
            state  <= ST_START;
            s      <= '0;
            o_busy <= 1'b1;
          end
        end

        ST_START: begin
          if (i_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= ST_DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (i_tick) begin
            if (s == S_BIT) begin
              // Right shift: first bit received ends up in the LSB.
              shift_reg <= {rx_s, shift_reg[NB_DATA-1:1]};
              s         <= '0;
              if (n == N_LAST) begin
                state <= ST_AFTER_DATA;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (i_tick) begin
            if (s == S_BIT) begin
              parity_bit <= rx_s;
              s          <= '0;
              state      <= ST_STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif

        ST_STOP: begin
          if (i_tick) begin
            if (s == S_STOP) begin
              // A bad stop bit still delivers the byte; the error flag tells.
              o_data      <= shift_reg;
              o_frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              o_parity_err <= (^shift_reg) ^ parity_bit;
`endif
              o_rx_done   <= 1'b1;
              s           <= '0;
              state       <= ST_IDLE;
              o_busy      <= 1'b0;
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a monitor
// pops and compares on every o_rx_done. Build with UART_RX_PARITY_EN to
// also exercise the parity bit.
module tb_uart_rx;

  localparam int TICK_DIV = 5;   // shortened tick spacing keeps the run small
  localparam int OS       = 16;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  int   done_ticks[$];
  exp_t mon_e;
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   tick_seen  = 0;
  int   div_cnt    = 0;

  uart_rx #(
    .NB_DATA       (8),
    .NB_STOP_TICKS (16),
    .OVERSAMPLE    (OS)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_rx_done    (o_rx_done),
    .o_frame_err  (o_frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (o_parity_err),
`endif
    .o_busy       (o_busy)
  );

  always #10 i_clock = ~i_clock;

  initial begin
    i_tick = 1'b0;
    forever begin
      @(negedge i_clock);
      if (div_cnt == TICK_DIV - 1) begin
        div_cnt = 0;
        i_tick  = 1'b1;
      end else begin
        div_cnt = div_cnt + 1;
        i_tick  = 1'b0;
      end
    end
  end

  always @(posedge i_clock) if (i_tick) tick_seen <= tick_seen + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge i_clock) begin
    if (o_rx_done === 1'b1) begin
      done_ticks.push_back(tick_seen);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got strobe with data 0x%0h, expected none", o_data);
      end else begin
        mon_e = sb.pop_front();
        check("rx_data", {24'h0, o_data}, {24'h0, mon_e.data});
        check("frame_err", {31'h0, o_frame_err}, {31'h0, mon_e.ferr});
`ifdef UART_RX_PARITY_EN
        check("parity_err", {31'h0, o_parity_err}, {31'h0, mon_e.perr});
`endif
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge i_clock);
      while (i_tick !== 1'b1) @(posedge i_clock);
    end
  endtask

  task automatic send_bit(input logic b, input int nticks);
    @(negedge i_clock);
    i_rx = b;
    wait_ticks(nticks);
  endtask

  // stop_ok=0 drives the stop bit low for 12 ticks only, long enough to be
  // sampled as a framing error but released before the re-triggered start
  // reaches mid-bit, so no spurious break frame follows.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    exp_t e;
    e.data = d;
    e.ferr = ~stop_ok;
    e.perr = ~par_ok;
    sb.push_back(e);
    send_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) send_bit(d[i], OS);
`ifdef UART_RX_PARITY_EN
    send_bit(par_ok ? ^d : ~^d, OS);
`endif
    if (stop_ok) begin
      send_bit(1'b1, OS);
    end else begin
      send_bit(1'b0, 12);
      send_bit(1'b1, 4);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v55;
    int         k;
    v55     = 8'h55;
    i_reset = 1'b0;
    i_rx    = 1'b1;
    repeat (3) @(negedge i_clock);
    check("rst_data", {24'h0, o_data}, 32'h0);
    check("rst_done", {31'h0, o_rx_done}, 32'h0);
    check("rst_ferr", {31'h0, o_frame_err}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    @(negedge i_clock);
    i_reset = 1'b1;
    send_bit(1'b1, 2 * OS);

    // Clean frame 0xA5, busy checked mid-frame.
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        wait_ticks(5 * OS);
        @(negedge i_clock);
        check("busy_in_frame", {31'h0, o_busy}, 32'h1);
      end
    join
    check("busy_after_frame", {31'h0, o_busy}, 32'h0);
    send_bit(1'b1, OS);

    // Four-tick low glitch: start seen, rejected at mid start bit.
    send_bit(1'b0, 2);
    @(negedge i_clock);
    check("busy_in_glitch", {31'h0, o_busy}, 32'h1);
    send_bit(1'b0, 2);
    send_bit(1'b1, OS);
    check("busy_after_glitch", {31'h0, o_busy}, 32'h0);
    check("data_after_glitch", {24'h0, o_data}, 32'hA5);

    // Framing error, then a clean frame clears the flag.
    send_frame(8'h3C, 1'b0, 1'b1);
    send_bit(1'b1, OS);
    send_frame(8'h01, 1'b1, 1'b1);
    send_bit(1'b1, OS);

    // Back-to-back frames, strobes one frame time apart.
    k = done_ticks.size();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_bit(1'b1, OS);
    check("b2b_strobes", done_ticks.size() - k, 32'd2);
    if (done_ticks.size() >= k + 2)
      check("b2b_spacing", done_ticks[k+1] - done_ticks[k], 32'd160);

    // Reset during data bit 4 of 0x55 aborts the frame.
    send_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) send_bit(v55[i], OS);
    send_bit(v55[4], 6);
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    check("arst_data", {24'h0, o_data}, 32'h0);
    check("arst_done", {31'h0, o_rx_done}, 32'h0);
    check("arst_ferr", {31'h0, o_frame_err}, 32'h0);
    check("arst_busy", {31'h0, o_busy}, 32'h0);
    repeat (3) @(negedge i_clock);
    i_reset = 1'b1;
    send_bit(1'b1, 2 * OS);
    check("busy_after_arst", {31'h0, o_busy}, 32'h0);
    send_frame(8'h81, 1'b1, 1'b1);
    send_bit(1'b1, OS);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1, OS);
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1, OS);
`endif

    wait_ticks(OS);
    check("pending_expected", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
